// File: rtl/seg7_pkg.sv
// Shared types and constants for the seven-segment display scheduler.
package seg7_pkg;

    localparam int SEG_DATA_W = 32;
    localparam int DIGITS     = 8;

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DWELL,
        SCAN
    } state_t;

endpackage

// File: rtl/seg7_display_scheduler_rr_pick.sv
// Combinational round-robin picker: returns the first eligible index after
// rr_last, wrapping, so that the most recently served source comes last.
module rr_pick #(
    parameter int  N_SRC = 4,
    localparam int SW    = $clog2(N_SRC)
) (
    input  logic [N_SRC-1:0] eligible,
    input  logic [SW-1:0]    rr_last,
    output logic [SW-1:0]    pick,
    output logic             any
);

    logic [SW-1:0] idx;

    // Scan from farthest to nearest so the nearest eligible index wins.
    always_comb begin
        pick = '0;
        any  = 1'b0;
        idx  = '0;
        for (int k = N_SRC; k >= 1; k--) begin
            idx = SW'((int'(rr_last) + k) % N_SRC);
            if (eligible[idx]) begin
                pick = idx;
                any  = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seg7_display_scheduler.sv
// Shares one 8-digit hex display among N_SRC requesters. Sources are granted
// round-robin through a req/ack handshake; each shown source is held for at
// least DWELL_CYCLES, and a manual mode pins the display to a single source.
module seg7_display_scheduler
    import seg7_pkg::*;
#(
    parameter int  N_SRC        = 4,
    parameter int  DWELL_CYCLES = 50_000_000,
    localparam int SW           = $clog2(N_SRC)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N_SRC-1:0]            req,
    input  logic [SEG_DATA_W*N_SRC-1:0] data_flat,
    input  logic                        manual_en,
    input  logic [SW-1:0]               manual_sel,
    output logic [N_SRC-1:0]            ack,
    output logic [SEG_DATA_W-1:0]       disp_data,
    output logic [SW-1:0]               disp_src,
    output logic                        disp_valid,
    output logic                        busy
);

    localparam int CW = $clog2(DWELL_CYCLES);
    localparam logic [N_SRC-1:0] ONE = {{(N_SRC-1){1'b0}}, 1'b1};

    state_t                  state;
    state_t                  state_nxt;
    logic [N_SRC-1:0]        eligible;
    logic [SW-1:0]           pick;
    logic                    any;
    logic [SW-1:0]           gnt;
    logic [SW-1:0]           rr_last;
    logic [CW-1:0]           dwell_cnt;
    logic [SEG_DATA_W-1:0]   src_data [N_SRC];
    logic                    abort;
    logic                    refresh;

    // Unpack the flat data bus and mask requests down to the eligible set.
    always_comb begin
        eligible = '0;
        for (int i = 0; i < N_SRC; i++) begin
            src_data[i] = data_flat[SEG_DATA_W*i +: SEG_DATA_W];
            eligible[i] = req[i] && (!manual_en || (int'(manual_sel) == i));
        end
    end

    rr_pick #(
        .N_SRC (N_SRC)
    ) u_rr_pick (
        .eligible (eligible),
        .rr_last  (rr_last),
        .pick     (pick),
        .any      (any)
    );

    // Manual pin moved away from the shown source ends the dwell early; a
    // fresh request from the shown source is taken unless it was just acked.
    assign abort   = manual_en && (manual_sel != disp_src);
    assign refresh = (state == DWELL) && eligible[disp_src] && !ack[disp_src];
    assign busy    = (state == LOAD) || (state == DWELL);

    // FSM state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (any) state_nxt = LOAD;
            LOAD:    state_nxt = DWELL;
            DWELL:   if (abort || (dwell_cnt == '0)) state_nxt = SCAN;
            SCAN:    state_nxt = any ? LOAD : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Grant, capture, acknowledge and dwell-countdown registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            gnt        <= '0;
            rr_last    <= SW'(N_SRC - 1);
            dwell_cnt  <= '0;
            ack        <= '0;
            disp_data  <= '0;
            disp_src   <= '0;
            disp_valid <= 1'b0;
        end else begin
            ack <= '0;
            case (state)
                IDLE, SCAN: begin
                    if (any) gnt <= pick;
                end
                LOAD: begin
                    disp_data  <= src_data[gnt];
                    disp_src   <= gnt;
                    disp_valid <= 1'b1;
                    ack        <= ONE << gnt;
                    rr_last    <= gnt;
                    dwell_cnt  <= CW'(DWELL_CYCLES - 1);
                end
                DWELL: begin
                    if (dwell_cnt != '0) dwell_cnt <= dwell_cnt - CW'(1);
                    if (refresh) begin
                        disp_data <= src_data[disp_src];
                        ack       <= ONE << disp_src;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
